// File: rtl/alu_pkg.sv
// Shared definitions for the execute-stage ALU: operation encoding and default width.
package alu_pkg;

  localparam int ALU_WIDTH = 8;

  typedef enum logic [1:0] {
    ALU_AND = 2'b00,
    ALU_OR  = 2'b01,
    ALU_ADD = 2'b10,
    ALU_SUB = 2'b11
  } alu_op_e;

endpackage

// File: rtl/alu_addsub.sv
// Combinational adder/subtractor: SUB is folded into the adder as A + ~B + 1,
// so carry_out reads as "no borrow" for subtraction.
module alu_addsub
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out,
  output logic             overflow
);

  logic [WIDTH-1:0] w_b_eff;

  // Operand conditioning and the single shared carry chain.
  always_comb begin
    w_b_eff              = sub ? ~b : b;
    {carry_out, sum}     = {1'b0, a} + {1'b0, w_b_eff} + {{WIDTH{1'b0}}, sub};
    // Signed overflow: both effective operands agree in sign but the sum does not.
    overflow             = (a[WIDTH-1] == w_b_eff[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
  end

endmodule

// File: rtl/alu_8bit.sv
// Registered ALU: operation select, one-cycle result/flag registers and a valid
// pipeline bit. Outputs hold between valid operations.
module alu_8bit
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic [1:0]       alu_control,
  output logic             out_valid,
  output logic [WIDTH-1:0] alu_result,
  output logic             zero,
  output logic             carry,
  output logic             overflow,
  output logic             negative
);

  alu_op_e          w_op;
  logic             w_sub;
  logic [WIDTH-1:0] w_sum;
  logic             w_add_carry;
  logic             w_add_ovf;
  logic [WIDTH-1:0] w_next_result;
  logic             w_next_carry;
  logic             w_next_ovf;

  logic [WIDTH-1:0] r_result;
  logic             r_carry;
  logic             r_ovf;
  logic             r_out_valid;

  assign w_op  = alu_op_e'(alu_control);
  assign w_sub = (w_op == ALU_SUB);

  alu_addsub #(.WIDTH(WIDTH)) u_addsub (
    .a         (src_a),
    .b         (src_b),
    .sub       (w_sub),
    .sum       (w_sum),
    .carry_out (w_add_carry),
    .overflow  (w_add_ovf)
  );

  // Operation mux; logic ops never report carry or overflow.
  always_comb begin
    w_next_result = {WIDTH{1'b0}};
    w_next_carry  = 1'b0;
    w_next_ovf    = 1'b0;
    case (w_op)
      ALU_AND: w_next_result = src_a & src_b;
      ALU_OR:  w_next_result = src_a | src_b;
      ALU_ADD, ALU_SUB: begin
        w_next_result = w_sum;
        w_next_carry  = w_add_carry;
        w_next_ovf    = w_add_ovf;
      end
      default: begin
        w_next_result = {WIDTH{1'b0}};
        w_next_carry  = 1'b0;
        w_next_ovf    = 1'b0;
      end
    endcase
  end

  // Result registers load only on in_valid, so idle-cycle inputs never reach the outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_result    <= {WIDTH{1'b0}};
      r_carry     <= 1'b0;
      r_ovf       <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      r_out_valid <= in_valid;
      if (in_valid) begin
        r_result <= w_next_result;
        r_carry  <= w_next_carry;
        r_ovf    <= w_next_ovf;
      end
    end
  end

  assign out_valid  = r_out_valid;
  assign alu_result = r_result;
  assign carry      = r_carry;
  assign overflow   = r_ovf;
  assign zero       = (r_result == {WIDTH{1'b0}});
  assign negative   = r_result[WIDTH-1];

endmodule

// File: tb/tb_alu_8bit.sv
// Bench for alu_8bit: integer-arithmetic reference model checked every cycle,
// plus directed vectors with literal expectations.
module tb_alu_8bit;

  logic       clk;
  logic       reset;
  logic       in_valid;
  logic [7:0] src_a;
  logic [7:0] src_b;
  logic [1:0] alu_control;
  logic       out_valid;
  logic [7:0] alu_result;
  logic       zero;
  logic       carry;
  logic       overflow;
  logic       negative;

  int n_total = 0;
  int n_pass  = 0;

  // Reference model state: what the outputs must be after the latest edge.
  int m_res   = 0;
  int m_c     = 0;
  int m_v     = 0;
  int m_valid = 0;

  alu_8bit dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .src_a       (src_a),
    .src_b       (src_b),
    .alu_control (alu_control),
    .out_valid   (out_valid),
    .alu_result  (alu_result),
    .zero        (zero),
    .carry       (carry),
    .overflow    (overflow),
    .negative    (negative)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
  endtask

  function automatic int to_signed8(input int x);
    return (x > 127) ? x - 256 : x;
  endfunction

  function automatic void model_op(input int a, input int b, input int op,
                                   output int res, output int c, output int v);
    int s;
    res = 0; c = 0; v = 0;
    case (op)
      0: res = a & b;
      1: res = a | b;
      2: begin
        res = (a + b) % 256;
        c   = (a + b > 255) ? 1 : 0;
        s   = to_signed8(a) + to_signed8(b);
        v   = (s > 127 || s < -128) ? 1 : 0;
      end
      default: begin
        res = (a - b + 256) % 256;
        c   = (a >= b) ? 1 : 0;
        s   = to_signed8(a) - to_signed8(b);
        v   = (s > 127 || s < -128) ? 1 : 0;
      end
    endcase
  endfunction

  always @(posedge clk or posedge reset) begin
    int r, c, v;
    if (reset) begin
      m_res = 0; m_c = 0; m_v = 0; m_valid = 0;
    end else begin
      m_valid = in_valid ? 1 : 0;
      if (in_valid) begin
        model_op(int'(src_a), int'(src_b), int'(alu_control), r, c, v);
        m_res = r; m_c = c; m_v = v;
      end
    end
  end

  // Compare process: DUT outputs against the model on every falling edge.
  always @(negedge clk) begin
    chk("cyc_result",   32'(alu_result), 32'(m_res));
    chk("cyc_carry",    32'(carry),      32'(m_c));
    chk("cyc_overflow", 32'(overflow),   32'(m_v));
    chk("cyc_valid",    32'(out_valid),  32'(m_valid));
    chk("cyc_zero",     32'(zero),       32'((m_res == 0) ? 1 : 0));
    chk("cyc_negative", 32'(negative),   32'((m_res >= 128) ? 1 : 0));
  end

  task automatic drive(input logic v, input logic [7:0] a, input logic [7:0] b, input logic [1:0] op);
    @(negedge clk);
    in_valid    = v;
    src_a       = a;
    src_b       = b;
    alu_control = op;
  endtask

  task automatic check_out(input string name, input logic [7:0] er, input logic ez,
                           input logic ec, input logic ev, input logic en, input logic eval);
    chk({name, "_result"},   32'(alu_result), 32'(er));
    chk({name, "_zero"},     32'(zero),       32'(ez));
    chk({name, "_carry"},    32'(carry),      32'(ec));
    chk({name, "_overflow"}, 32'(overflow),   32'(ev));
    chk({name, "_negative"}, 32'(negative),   32'(en));
    chk({name, "_valid"},    32'(out_valid),  32'(eval));
  endtask

  task automatic do_op(input string name, input logic [7:0] a, input logic [7:0] b, input logic [1:0] op,
                       input logic [7:0] er, input logic ez, input logic ec, input logic ev, input logic en);
    drive(1'b1, a, b, op);
    @(posedge clk);
    #1;
    check_out(name, er, ez, ec, ev, en, 1'b1);
  endtask

  function automatic logic [7:0] pick_operand();
    logic [7:0] corners [6];
    corners[0] = 8'h00; corners[1] = 8'h01; corners[2] = 8'h7F;
    corners[3] = 8'h80; corners[4] = 8'h81; corners[5] = 8'hFF;
    if ($urandom_range(0, 1) == 0) return corners[$urandom_range(0, 5)];
    else return 8'($urandom_range(0, 255));
  endfunction

  initial begin
    reset = 1'b1; in_valid = 1'b0; src_a = 8'h00; src_b = 8'h00; alu_control = 2'b00;
    repeat (2) @(posedge clk);
    #1;
    check_out("reset", 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    reset = 1'b0;

    // Each directed op follows the previous one back-to-back.
    do_op("and",     8'h02, 8'h81, 2'b00, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
    do_op("or",      8'h83, 8'h81, 2'b01, 8'h83, 1'b0, 1'b0, 1'b0, 1'b1);
    do_op("add_cv",  8'h83, 8'h81, 2'b10, 8'h04, 1'b0, 1'b1, 1'b1, 1'b0);
    do_op("add_v",   8'h7F, 8'h01, 2'b10, 8'h80, 1'b0, 1'b0, 1'b1, 1'b1);
    do_op("add_z",   8'hFF, 8'h01, 2'b10, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0);
    do_op("sub_c",   8'h83, 8'h81, 2'b11, 8'h02, 1'b0, 1'b1, 1'b0, 1'b0);
    do_op("sub_z",   8'h05, 8'h05, 2'b11, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0);
    do_op("sub_bor", 8'h00, 8'h01, 2'b11, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b1);
    do_op("sub_v",   8'h80, 8'h01, 2'b11, 8'h7F, 1'b0, 1'b1, 1'b1, 1'b0);

    // Idle cycles with changing operands must leave the last result in place.
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 8'(8'h11 * (i + 1)), 8'hFF, 2'(i));
      @(posedge clk);
      #1;
      check_out("hold", 8'h7F, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    end

    // Reset mid-cycle clears immediately; an op sampled under reset is dropped.
    do_op("pre_rst", 8'h7F, 8'h01, 2'b10, 8'h80, 1'b0, 1'b0, 1'b1, 1'b1);
    #2;
    reset = 1'b1;
    #1;
    check_out("rst_async", 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 8'hFF, 8'h01, 2'b10);
    @(posedge clk);
    #1;
    check_out("rst_drop", 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    reset    = 1'b0;
    in_valid = 1'b0;

    for (int i = 0; i < 1000; i++) begin
      drive(($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0, pick_operand(), pick_operand(),
            2'($urandom_range(0, 3)));
    end
    drive(1'b0, 8'h00, 8'h00, 2'b00);
    repeat (2) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/alu_8bit.md
Name: alu_8bit

Overview:
- Registered 8-bit ALU used as the datapath execute-stage arithmetic/logic unit.
- Supports four operations selected by a 2-bit control: AND, OR, ADD and SUB.
- Produces a result, a zero flag and carry/overflow/negative status.
- Inputs are sampled on a valid strobe; outputs appear one clock later and are held until the next valid operation.

Parameters:
- WIDTH, 8, operand and result width in bits; must be at least 2.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- in_valid  input  1  operands and control are sampled this cycle.
- src_a  input  WIDTH  operand A.
- src_b  input  WIDTH  operand B.
- alu_control  input  2  operation select: 00 AND, 01 OR, 10 ADD, 11 SUB.
- out_valid  output  1  result registers were loaded on the previous rising edge.
- alu_result  output  WIDTH  registered result.
- zero  output  1  high when alu_result == 0.
- carry  output  1  registered carry-out. ADD: carry out of the MSB. SUB: no-borrow (1 when A >= B unsigned). 0 for AND/OR.
- overflow  output  1  registered signed overflow for ADD/SUB; 0 for AND/OR.
- negative  output  1  MSB of alu_result.

Behaviour:
- Reset (asynchronous assert, released synchronously by the environment):
  - alu_result=0, carry=0, overflow=0, out_valid=0.
  - zero=1 and negative=0, because both are derived combinationally from alu_result.
- Latency: exactly 1 cycle. When in_valid=1 at a rising edge, the result and flags for that cycle's operands are visible after that edge, and out_valid=1 for that one cycle.
- When in_valid=0 at a rising edge: alu_result, carry and overflow hold their values; out_valid goes to 0.
- Back-to-back: in_valid may be high every cycle; each operation completes independently. There is no backpressure.
- Operations:
  - AND: A & B, bitwise.
  - OR: A | B, bitwise.
  - ADD: {carry, result} = A + B, WIDTH+1 bit sum; the result wraps modulo 2^WIDTH.
  - SUB: computed as A + ~B + 1 through the same adder. carry = adder carry-out, so 1 means no borrow. The result wraps modulo 2^WIDTH.
- Overflow:
  - ADD: set when A[MSB]==B[MSB] and result[MSB]!=A[MSB].
  - SUB: set when A[MSB]!=B[MSB] and result[MSB]!=A[MSB].
- Operands are unsigned for carry and two's-complement for overflow/negative; both interpretations are always reported.
- alu_control is a full 2-bit decode, so there are no illegal codes.
- X/undefined on the inputs while in_valid=0 must not affect any output.
- Reset asserted mid-stream: all registered outputs clear immediately, and any operation sampled on that edge is discarded.

Decomposition:
- Package alu_pkg:
  - enum alu_op_e (ALU_AND=2'b00, ALU_OR=2'b01, ALU_ADD=2'b10, ALU_SUB=2'b11).
  - Default WIDTH constant.
- Sub-module alu_addsub: purely combinational. Inputs a, b, sub; outputs sum, carry_out, overflow. Performs the invert-and-add-one for SUB.
- The top level performs operation muxing, the output registers, the valid pipeline and flag derivation.

Test Plan:
- Reset with in_valid=0 -> alu_result=0x00, zero=1, carry=0, overflow=0, out_valid=0; asserting reset mid-run clears the outputs immediately.
- AND 0x02,0x81 -> result 0x00, zero=1. OR 0x83,0x81 -> 0x83, zero=0, negative=1. Both have carry=0 and overflow=0; out_valid is high one cycle after in_valid.
- ADD:
  - 0x83+0x81 -> 0x04, carry=1, overflow=1.
  - 0x7F+0x01 -> 0x80, carry=0, overflow=1, negative=1.
  - 0xFF+0x01 -> 0x00, zero=1, carry=1, overflow=0.
- SUB:
  - 0x83-0x81 -> 0x02, carry=1, overflow=0.
  - 0x05-0x05 -> 0x00, zero=1, carry=1.
  - 0x00-0x01 -> 0xFF, carry=0, negative=1.
  - 0x80-0x01 -> 0x7F, overflow=1.
- Hold/throughput: four back-to-back valid ops give four consecutive correct results with out_valid high each cycle. Then in_valid=0 with changing operands -> outputs hold the last result and out_valid=0.
- Randomized self-check: 1000 random (A, B, op) triples with random in_valid gaps, compared against a reference model of result/carry/overflow/zero/negative; covers all four ops at their carry and overflow boundaries.
